// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: host-side command responder on the uart byte interface.
// Decodes 5-byte frames {SYNC_CMD, CMD, ADDR, DATA, SUM} into 8-bit register bus
// reads and writes, then sends a reply frame back through the uart transmitter.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rx_received/rx_byte received byte strobe and data
//   rx_error            uart framing error strobe
//   tx_free             uart transmit register empty
//   transmit/tx_byte    one-cycle send strobe and byte
//   reg_addr/reg_wdata  register bus address and write data (held between commands)
//   reg_we/reg_re       one-cycle write / read strobes
//   reg_rdata           read data, valid one clock after reg_re
//   busy                high whenever not hunting for a frame
//   err_count           (UART_CMD_STATS_EN only) saturating error counter
//
// Optional feature macro: UART_CMD_STATS_EN adds err_count, readable at ADDR 8'hFF.
module uart_cmd_responder #(
  parameter int unsigned CLOCKFRQ      = 48_000_000,
  parameter int unsigned TIMEOUT_TICKS = CLOCKFRQ / 1000,
  parameter logic [7:0]  SYNC_CMD      = 8'hA5,
  parameter logic [7:0]  SYNC_RSP      = 8'h5A,
  parameter logic [7:0]  NAK_BYTE      = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_received,
  input  logic [7:0] rx_byte,
  input  logic       rx_error,
  input  logic       tx_free,
  output logic       transmit,
  output logic [7:0] tx_byte,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
`ifdef UART_CMD_STATS_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0] S_HUNT  = 4'd0;
  localparam logic [3:0] S_CMD   = 4'd1;
  localparam logic [3:0] S_ADDR  = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_SUM   = 4'd4;
  localparam logic [3:0] S_EXEC  = 4'd5;
  localparam logic [3:0] S_RSAMP = 4'd6;
  localparam logic [3:0] S_TX    = 4'd7;
  localparam logic [3:0] S_TXGAP = 4'd8;

  // Decoded operation, fixed when the SUM byte is accepted.
  localparam logic [1:0] OP_NAK = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;
  localparam logic [1:0] OP_RDI = 2'd3;  // internal read of err_count

  logic [3:0]       state;
  logic [7:0]       cmd_q, addr_q, data_q, sum_q;
  logic [1:0]       op_q, op_next;
  logic [3:0][7:0]  rsp;
  logic [1:0]       idx, last_idx;
  logic [31:0]      tmo;
  logic             in_frame, rx_ok, timeout_hit;
  logic [7:0]       rd_val;

  assign in_frame    = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) ||
                       (state == S_SUM);
  // A simultaneous error drops the byte.
  assign rx_ok       = rx_received && !rx_error;
  // Decrementing from 1 reaches 0, which is the abort point.
  assign timeout_hit = (tmo <= 32'd1);

  assign busy     = (state != S_HUNT);
  assign transmit = (state == S_TX) && tx_free;
  assign tx_byte  = transmit ? rsp[idx] : 8'h00;
  assign reg_we   = (state == S_EXEC) && (op_q == OP_WR);
  assign reg_re   = (state == S_EXEC) && (op_q == OP_RD);

  always_comb begin
    op_next = OP_NAK;
    if (rx_byte == sum_q) begin
      if (cmd_q == 8'h01) op_next = OP_WR;
      else if (cmd_q == 8'h02) op_next = OP_RD;
    end
`ifdef UART_CMD_STATS_EN
    if (op_next == OP_RD && addr_q == 8'hFF) op_next = OP_RDI;
`endif
  end

`ifdef UART_CMD_STATS_EN
  assign rd_val = (op_q == OP_RDI) ? err_count : reg_rdata;
`else
  assign rd_val = reg_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      cmd_q     <= 8'h00;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      sum_q     <= 8'h00;
      op_q      <= OP_NAK;
      rsp       <= '0;
      idx       <= 2'd0;
      last_idx  <= 2'd0;
      tmo       <= 32'd0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
    end else begin
      case (state)
        S_HUNT: begin
          if (rx_ok && rx_byte == SYNC_CMD) begin
            state <= S_CMD;
            tmo   <= TIMEOUT_TICKS;
          end
        end
        S_CMD, S_ADDR, S_DATA, S_SUM: begin
          if (rx_error) begin
            state <= S_HUNT;
            tmo   <= 32'd0;
          end else if (rx_received) begin
            tmo <= TIMEOUT_TICKS;
            case (state)
              S_CMD: begin
                cmd_q <= rx_byte;
                sum_q <= rx_byte;
                state <= S_ADDR;
              end
              S_ADDR: begin
                addr_q <= rx_byte;
                sum_q  <= sum_q + rx_byte;
                state  <= S_DATA;
              end
              S_DATA: begin
                data_q <= rx_byte;
                sum_q  <= sum_q + rx_byte;
                state  <= S_SUM;
              end
              default: begin
                // Bus outputs only change for accepted commands, so they are
                // already stable during the S_EXEC strobe cycle.
                op_q  <= op_next;
                tmo   <= 32'd0;
                state <= S_EXEC;
                if (op_next != OP_NAK) reg_addr <= addr_q;
                if (op_next == OP_WR) reg_wdata <= data_q;
              end
            endcase
          end else if (timeout_hit) begin
            state <= S_HUNT;
            tmo   <= 32'd0;
          end else begin
            tmo <= tmo - 32'd1;
          end
        end
        S_EXEC: begin
          idx <= 2'd0;
          if (op_q == OP_NAK) begin
            rsp[0]   <= NAK_BYTE;
            last_idx <= 2'd0;
            state    <= S_TX;
          end else if (op_q == OP_WR) begin
            rsp      <= {reg_addr + reg_wdata, reg_wdata, reg_addr, SYNC_RSP};
            last_idx <= 2'd3;
            state    <= S_TX;
          end else begin
            state <= S_RSAMP;
          end
        end
        S_RSAMP: begin
          rsp      <= {reg_addr + rd_val, rd_val, reg_addr, SYNC_RSP};
          last_idx <= 2'd3;
          state    <= S_TX;
        end
        S_TX: begin
          if (tx_free) state <= S_TXGAP;
        end
        S_TXGAP: begin
          // tx_free lags transmit by a cycle, so it is not looked at here.
          if (idx == last_idx) begin
            state <= S_HUNT;
          end else begin
            idx   <= idx + 2'd1;
            state <= S_TX;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

`ifdef UART_CMD_STATS_EN
  logic err_inc;
  assign err_inc = (in_frame && rx_error) ||
                   (in_frame && !rx_received && timeout_hit) ||
                   (state == S_EXEC && op_q == OP_NAK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'h00;
    end else if (err_inc && err_count != 8'hFF) begin
      err_count <= err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  localparam int unsigned TICKS = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_error = 1'b0;
  logic       tx_free = 1'b1;
  logic [7:0] reg_rdata = 8'h00;
  logic       transmit, reg_we, reg_re, busy;
  logic [7:0] tx_byte, reg_addr, reg_wdata;

  uart_cmd_responder #(
    .TIMEOUT_TICKS(TICKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_received(rx_received),
    .rx_byte    (rx_byte),
    .rx_error   (rx_error),
    .tx_free    (tx_free),
    .transmit   (transmit),
    .tx_byte    (tx_byte),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [7:0]  tx_q[$];
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];
  logic [7:0]  pending_rdata = 8'h00;

  typedef struct {
    logic [39:0] frame;
    logic [7:0]  rdata;
    logic [1:0]  kind;   // 0 nak, 1 write, 2 read
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] rsp;    // reply bytes, first byte in the top
    int unsigned rsp_len;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every transmit strobe must match the next queued reply byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (transmit) begin
        tx_seen++;
        check("tx_free_at_strobe", 32'(tx_free), 32'd1);
        check("tx_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) check("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
      end
      if (reg_we) begin
        check("we_expected", 32'(we_q.size() != 0), 32'd1);
        if (we_q.size() != 0) check("we_addr_data", {16'h0, reg_addr, reg_wdata},
                                    {16'h0, we_q.pop_front()});
      end
    end
  end

  // Register bus model: read data appears exactly one clock after reg_re.
  always @(negedge clk) begin
    if (!rst && reg_re) begin
      check("re_expected", 32'(re_q.size() != 0), 32'd1);
      if (re_q.size() != 0) check("re_addr", 32'(reg_addr), 32'(re_q.pop_front()));
      @(posedge clk);
      #1 reg_rdata = pending_rdata;
      @(posedge clk);
      #1 reg_rdata = 8'h00;
    end
  end

  // UART model: tx_free falls one cycle late after a transmit and stays low a while.
  always @(negedge clk) begin
    if (transmit) begin
      @(posedge clk);
      @(posedge clk);
      #1 tx_free = 1'b0;
      repeat (4) @(posedge clk);
      #1 tx_free = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_byte = b;
    rx_received = 1'b1;
    @(posedge clk);
    #1 rx_received = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  task automatic push_rsp(input logic [31:0] r, input int unsigned n);
    for (int i = 0; i < int'(n); i++) tx_q.push_back(r[31-8*i -: 8]);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!busy && tx_q.size() == 0) break;
    end
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_txq_left"}, 32'(tx_q.size()), 32'd0);
  endtask

  task automatic expect_write_reply(input string name);
    we_q.push_back(16'h103C);
    push_rsp(32'h5A103C4C, 4);
    send_frame(40'hA5_01_10_3C_4D);
    check({name, "_we_latency"}, 32'(reg_we), 32'd1);
    wait_idle(name);
  endtask

  vec_t vecs[7];
  int   base;

  initial begin
    vecs[0] = '{40'hA5_01_10_3C_4D, 8'h00, 2'd1, 8'h10, 8'h3C, 32'h5A103C4C, 4};
    vecs[1] = '{40'hA5_02_20_00_22, 8'h99, 2'd2, 8'h20, 8'h00, 32'h5A2099B9, 4};
    vecs[2] = '{40'hA5_01_10_3C_00, 8'h00, 2'd0, 8'h00, 8'h00, 32'h15000000, 1};
    vecs[3] = '{40'hA5_07_00_00_07, 8'h00, 2'd0, 8'h00, 8'h00, 32'h15000000, 1};
    vecs[4] = '{40'hA5_01_FF_FF_FF, 8'h00, 2'd1, 8'hFF, 8'hFF, 32'h5AFFFFFE, 4};
    vecs[5] = '{40'hA5_01_A5_A5_4B, 8'h00, 2'd1, 8'hA5, 8'hA5, 32'h5AA5A54A, 4};
    vecs[6] = '{40'hA5_02_30_11_43, 8'h5C, 2'd2, 8'h30, 8'h00, 32'h5A305C8C, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_re", 32'(reg_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Garbage before sync is discarded
    send_byte(8'h33);
    send_byte(8'h77);
    check("hunt_discard", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      pending_rdata = vecs[i].rdata;
      if (vecs[i].kind == 2'd1) we_q.push_back({vecs[i].addr, vecs[i].data});
      if (vecs[i].kind == 2'd2) re_q.push_back(vecs[i].addr);
      push_rsp(vecs[i].rsp, vecs[i].rsp_len);
      send_frame(vecs[i].frame);
      check($sformatf("v%0d_we_strobe", i), 32'(reg_we), 32'(vecs[i].kind == 2'd1));
      check($sformatf("v%0d_re_strobe", i), 32'(reg_re), 32'(vecs[i].kind == 2'd2));
      wait_idle($sformatf("v%0d", i));
    end
    // Bus outputs hold: last read addr 30, last write data A5
    check("hold_reg_addr", 32'(reg_addr), 32'h30);
    check("hold_reg_wdata", 32'(reg_wdata), 32'hA5);

    // Inter-byte timeout: not yet at TICKS-1 idle clocks, fired by TICKS+1
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (TICKS - 1) @(posedge clk);
    #1 check("tmo_not_yet", 32'(busy), 32'd1);
    repeat (2) @(posedge clk);
    #1 check("tmo_fired", 32'(busy), 32'd0);
    expect_write_reply("after_tmo");

    // rx_error abort after ADDR
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h10);
    @(posedge clk);
    #1 rx_error = 1'b1;
    @(posedge clk);
    #1 rx_error = 1'b0;
    check("rxerr_abort", 32'(busy), 32'd0);
    expect_write_reply("after_rxerr");

    // Error and byte in the same cycle: error wins
    send_byte(8'hA5);
    send_byte(8'h01);
    @(posedge clk);
    #1 rx_byte = 8'h10;
    rx_received = 1'b1;
    rx_error = 1'b1;
    @(posedge clk);
    #1 rx_received = 1'b0;
    rx_error = 1'b0;
    check("err_wins", 32'(busy), 32'd0);

    // Reset mid-reply after the second transmit strobe
    base = tx_seen;
    we_q.push_back(16'h103C);
    push_rsp(32'h5A103C4C, 4);
    send_frame(40'hA5_01_10_3C_4D);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (tx_seen >= base + 2) break;
    end
    check("midreply_reached", 32'(tx_seen - base), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("midrst_transmit", 32'(transmit), 32'd0);
    check("midrst_tx_byte", 32'(tx_byte), 32'd0);
    check("midrst_reg_addr", 32'(reg_addr), 32'd0);
    check("midrst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    tx_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    check("midrst_no_tx", 32'(tx_seen - base), 32'd2);
    expect_write_reply("after_midrst");

    check("we_q_empty", 32'(we_q.size()), 32'd0);
    check("re_q_empty", 32'(re_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_responder.md
Name: uart_cmd_responder

Overview:
- Host-side command responder; sits on the receive/transmit byte interface of the team's `uart` block.
- Decodes fixed 5-byte command frames from the UART receive side and performs 8-bit register reads/writes on a simple register bus.
- Returns a reply frame through the UART transmit side.
- Lets the host configure and poll orbtrace registers over the same serial link that carries trace data.

Parameters:
- CLOCKFRQ, 48_000_000, clock frequency in Hz.
- TIMEOUT_TICKS, CLOCKFRQ/1000, maximum idle clocks between bytes inside a frame; 1 ms at the default clock.
- SYNC_CMD, 8'hA5, command frame sync byte.
- SYNC_RSP, 8'h5A, reply frame sync byte.
- NAK_BYTE, 8'h15, single-byte error reply.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_received  in  1  one-cycle strobe: byte available (UART `received`).
- rx_byte  in  8  received byte, valid with rx_received.
- rx_error  in  1  one-cycle UART framing error strobe (UART `recv_error`).
- tx_free  in  1  UART transmit register empty.
- transmit  out  1  one-cycle strobe: send tx_byte.
- tx_byte  out  8  byte to send.
- reg_addr  out  8  register address.
- reg_wdata  out  8  write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data, valid exactly one clock after reg_re.
- busy  out  1  high in any state other than S_HUNT.

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. All outputs 0, state S_HUNT, timeout counter 0. Reset mid-frame or mid-reply abandons everything immediately; no partial reply is completed.
- Command frame: SYNC_CMD, CMD, ADDR, DATA, SUM, where SUM = (CMD+ADDR+DATA) mod 256.
  - CMD 8'h01 = write; CMD 8'h02 = read (DATA is ignored but included in SUM).
  - No escaping: 8'hA5 after the sync byte is ordinary data.
- States:
  - S_HUNT: discard bytes until rx_byte==SYNC_CMD, then go to S_CMD.
  - S_CMD, S_ADDR, S_DATA, S_SUM: each captures one byte on rx_received and accumulates the 8-bit sum (carry discarded).
  - S_EXEC: entered the cycle after the SUM byte is accepted.
    - SUM mismatch or CMD not 01/02: no bus strobe; reply = NAK_BYTE only.
    - Write: reg_we=1 for exactly this cycle with reg_addr/reg_wdata stable; reply = SYNC_RSP, ADDR, DATA, (ADDR+DATA) mod 256.
    - Read: reg_re=1 for this cycle, then go to S_RSAMP.
  - S_RSAMP: latch reg_rdata; reply = SYNC_RSP, ADDR, RDATA, (ADDR+RDATA) mod 256.
  - S_TX: when tx_free==1, drive transmit=1 for one cycle with tx_byte set to the current reply byte, then go to S_TXGAP.
  - S_TXGAP: one cycle in which tx_free is ignored (UART drops tx_free one cycle late). Then go to S_TX for the next byte, or to S_HUNT after the last byte.
- reg_addr and reg_wdata hold their last values between commands.
- Inter-byte timeout, in S_CMD..S_SUM:
  - The counter reloads to TIMEOUT_TICKS on each accepted byte and decrements otherwise.
  - Reaching 0 returns to S_HUNT silently, with no NAK.
- rx_error in S_CMD..S_SUM: abort to S_HUNT silently. In S_HUNT: ignored.
- Bytes received in S_EXEC..S_TXGAP are discarded; hunting resumes only after the reply completes.
- rx_received and rx_error asserted in the same cycle: the error wins and the byte is dropped.
- Latency: reg_we fires 1 clock after the SUM strobe; reg_re also fires 1 clock after it. The first transmit strobe fires no earlier than 2 clocks (write) or 3 clocks (read) after the SUM strobe.

Optional Feature:
- Macro: UART_CMD_STATS_EN.
- When defined, adds output port err_count (8 bits):
  - Increments once per NAK, timeout abort, or rx_error abort.
  - Saturates at 8'hFF and clears only on rst.
  - Host can read it with CMD 8'h02, ADDR 8'hFF; this address is served internally, so reg_re is not asserted.
- When undefined: the port and counter are absent, and ADDR 8'hFF is an ordinary bus read.

Test Plan:
- Write: send A5 01 10 3C 4D -> one reg_we pulse with reg_addr=10, reg_wdata=3C; reply 5A 10 3C 4C; exactly four transmit strobes, each with tx_free high.
- Read: send A5 02 20 00 22, reg_rdata=99 one cycle after reg_re -> one reg_re pulse with reg_addr=20; reply 5A 20 99 B9.
- Bad checksum and unknown CMD:
  - A5 01 10 3C 00 -> no reg_we; reply 15.
  - A5 07 00 00 07 -> reply 15.
- Checksum wrap: send A5 01 FF FF FF -> reg_we with addr FF, data FF; reply 5A FF FF FE.
- Abort and resync:
  - Send A5 01 10, idle TIMEOUT_TICKS+1 clocks -> no transmit.
  - Then send A5 01 10 3C 4D -> normal write and reply.
  - Repeat with rx_error pulsed after ADDR -> same result.
- Reset mid-reply: assert rst after the second reply byte's transmit strobe -> all outputs 0 immediately; the next valid frame is processed normally.
